// File: rtl/axi_lite_master.sv
// axi_lite_master
// AXI4-Lite initiator: turns single-word PL register commands into AXI4-Lite
// write/read transactions and returns exactly one response per command.
// One transaction is outstanding at a time; a sticky stall monitor flags
// transactions that stay on the bus for TIMEOUT_CYCLES or longer.
//
// Ports
//   m00_axi_aclk / m00_axi_aresetn  clock, asynchronous active-low reset
//   cmd_*      command channel (valid/ready, write flag, byte addr, data, strobes)
//   rsp_*      response channel (valid/ready, write flag, read data, BRESP/RRESP)
//   busy       high whenever the engine is not idle
//   timeout_err / timeout_clr  sticky stall flag and its clear pulse
//   m00_axi_*  AXI4-Lite master channels AW, W, B, AR, R
module axi_lite_master #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              m00_axi_aclk,
  input  logic              m00_axi_aresetn,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,

  output logic              busy,
  output logic              timeout_err,
  input  logic              timeout_clr,

  output logic [ADDR_W-1:0] m00_axi_awaddr,
  output logic [2:0]        m00_axi_awprot,
  output logic              m00_axi_awvalid,
  input  logic              m00_axi_awready,

  output logic [31:0]       m00_axi_wdata,
  output logic [3:0]        m00_axi_wstrb,
  output logic              m00_axi_wvalid,
  input  logic              m00_axi_wready,

  input  logic [1:0]        m00_axi_bresp,
  input  logic              m00_axi_bvalid,
  output logic              m00_axi_bready,

  output logic [ADDR_W-1:0] m00_axi_araddr,
  output logic [2:0]        m00_axi_arprot,
  output logic              m00_axi_arvalid,
  input  logic              m00_axi_arready,

  input  logic [31:0]       m00_axi_rdata,
  input  logic [1:0]        m00_axi_rresp,
  input  logic              m00_axi_rvalid,
  output logic              m00_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_RSP
  } state_e;

  localparam logic [15:0]       TO_LIMIT   = 16'(TIMEOUT_CYCLES);
  // Masking (rather than slicing) keeps every cmd_addr bit in use.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                rsp_write_q, rsp_write_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic                counting;
  logic [15:0]         cnt_inc;
  logic                to_set;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_ready_q && cmd_valid) begin
          addr_d  = cmd_addr & ALIGN_MASK;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          cnt_d   = '0;
          if (cmd_write) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; leave once neither is pending.
        if (awvalid_q && m00_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m00_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (bready_q && m00_axi_bvalid) begin
          state_d     = S_RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m00_axi_bresp;
        end
      end
      S_RD_REQ: begin
        if (arvalid_q && m00_axi_arready) begin
          state_d   = S_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (rready_q && m00_axi_rvalid) begin
          state_d     = S_RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m00_axi_rdata;
          rsp_resp_d  = m00_axi_rresp;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);

    // Stall monitor: counts every bus-side cycle, saturating. The flag is
    // re-armed each cycle the count is at/over the limit, so a clear pulse
    // during a persisting stall has no lasting effect.
    counting = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
               (state_q == S_RD_REQ) || (state_q == S_RD_DATA);
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
    if (counting) cnt_d = cnt_inc;
    to_set    = counting && (TO_LIMIT != '0) && (cnt_inc >= TO_LIMIT);
    timeout_d = to_set | (timeout_q & ~timeout_clr);
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign busy            = busy_q;
  assign timeout_err     = timeout_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_write       = rsp_write_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_resp        = rsp_resp_q;

  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_awprot  = '0;
  assign m00_axi_awvalid = awvalid_q;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_wstrb   = wstrb_q;
  assign m00_axi_wvalid  = wvalid_q;
  assign m00_axi_bready  = bready_q;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_arprot  = '0;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master
// Directed bench for axi_lite_master. A transaction-level model (which
// channel handshakes of the current command have happened) predicts every
// output each cycle; literal checks pin latency, addresses and data.
module tb_axi_lite_master;

  localparam int unsigned AW       = 8;
  localparam int unsigned TO_T     = 16;
  localparam int unsigned WAIT_MAX = 64;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy, timeout_err, timeout_clr;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  int unsigned aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;

  axi_lite_master #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO_T)) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .timeout_err(timeout_err), .timeout_clr(timeout_clr),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot),
    .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------
  logic          m_inflight, m_write, m_aw_done, m_w_done, m_ar_done, m_got;
  logic          m_ready, m_to;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_resp;
  int unsigned   m_cnt;
  logic          e_aw, e_w, e_b, e_ar, e_r, e_rsp;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_inflight = 0; m_write = 0; m_aw_done = 0; m_w_done = 0; m_ar_done = 0;
      m_got = 0; m_ready = 0; m_to = 0; m_addr = '0; m_wdata = '0;
      m_rdata = '0; m_wstrb = '0; m_resp = '0; m_cnt = 0;
    end
    e_aw  = m_inflight &&  m_write && !m_aw_done;
    e_w   = m_inflight &&  m_write && !m_w_done;
    e_b   = m_inflight &&  m_write && m_aw_done && m_w_done && !m_got;
    e_ar  = m_inflight && !m_write && !m_ar_done;
    e_r   = m_inflight && !m_write && m_ar_done && !m_got;
    e_rsp = m_inflight && m_got;

    check("cmd_ready",   32'(cmd_ready),   32'(m_ready));
    check("busy",        32'(busy),        32'(m_inflight));
    check("timeout_err", 32'(timeout_err), 32'(m_to));
    check("awvalid",     32'(awvalid),     32'(e_aw));
    check("wvalid",      32'(wvalid),      32'(e_w));
    check("bready",      32'(bready),      32'(e_b));
    check("arvalid",     32'(arvalid),     32'(e_ar));
    check("rready",      32'(rready),      32'(e_r));
    check("rsp_valid",   32'(rsp_valid),   32'(e_rsp));
    check("prot",        32'({awprot, arprot}), 32'(0));
    if (e_aw) check("awaddr", 32'(awaddr), 32'(m_addr));
    if (e_w) begin
      check("wdata", wdata, m_wdata);
      check("wstrb", 32'(wstrb), 32'(m_wstrb));
    end
    if (e_ar) check("araddr", 32'(araddr), 32'(m_addr));
    if (e_rsp) begin
      check("rsp_write", 32'(rsp_write), 32'(m_write));
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("rsp_resp",  32'(rsp_resp), 32'(m_resp));
    end

    if (rst_n) begin
      logic to_set;
      logic accept;
      to_set = 1'b0;
      accept = m_ready && cmd_valid;
      if (m_inflight && !m_got) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt >= TO_T) to_set = 1'b1;
      end
      m_to = to_set ? 1'b1 : (timeout_clr ? 1'b0 : m_to);
      if (e_aw && awready) m_aw_done = 1;
      if (e_w && wready)   m_w_done  = 1;
      if (e_ar && arready) m_ar_done = 1;
      if (e_b && bvalid) begin m_got = 1; m_rdata = '0;    m_resp = bresp; end
      if (e_r && rvalid) begin m_got = 1; m_rdata = rdata; m_resp = rresp; end
      if (e_rsp && rsp_ready) begin m_inflight = 0; m_got = 0; end
      if (accept) begin
        m_inflight = 1; m_write = cmd_write; m_addr = cmd_addr & 8'hFC;
        m_wdata = cmd_wdata; m_wstrb = cmd_wstrb; m_cnt = 0;
        m_aw_done = 0; m_w_done = 0; m_ar_done = 0; m_got = 0;
      end
      m_ready = !m_inflight;
    end
  end

  // ---------------- AXI slave with configurable ready/valid delays -------
  initial begin
    int unsigned aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic aw_got, w_got, b_pend, r_pend;
    logic n_aw, n_w, n_ar, n_b, n_r;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0;
      end else begin
        if (awvalid && awready) begin aw_wait = 0; aw_got = 1; end
        else if (awvalid) aw_wait++;
        if (wvalid && wready) begin w_wait = 0; w_got = 1; end
        else if (wvalid) w_wait++;
        if (bvalid && bready) b_pend = 0;
        else if (b_pend) b_wait++;
        if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
        if (rvalid && rready) r_pend = 0;
        else if (r_pend) r_wait++;
        if (arvalid && arready) begin ar_wait = 0; r_pend = 1; r_wait = 0; end
        else if (arvalid) ar_wait++;
        n_aw = aw_wait >= aw_delay;
        n_w  = w_wait >= w_delay;
        n_ar = ar_wait >= ar_delay;
        n_b  = b_pend && (b_wait >= b_delay);
        n_r  = r_pend && (r_wait >= r_delay);
      end
      @(posedge clk);
      #1;
      awready = n_aw; wready = n_w; arready = n_ar; bvalid = n_b; rvalid = n_r;
    end
  end

  // ---------------- stimulus ---------------------------------------------
  task automatic start_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int unsigned n;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < WAIT_MAX);
    check("accept_wait", 32'(cmd_ready), 32'(1));
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int unsigned hold,
                        output int unsigned lat, output logic [7:0] c1_addr,
                        output logic [31:0] c1_wdata, output logic [31:0] r_rdata,
                        output logic [1:0] r_resp, output logic r_wr);
    rsp_ready = (hold == 0);
    start_cmd(wr, a, d, s);
    @(negedge clk);
    c1_addr  = wr ? awaddr : araddr;
    c1_wdata = wdata;
    lat = 1;
    while (!rsp_valid && lat < WAIT_MAX) begin @(negedge clk); lat++; end
    check("rsp_wait", 32'(rsp_valid), 32'(1));
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      rsp_ready = 1;
      @(negedge clk);
    end
    r_rdata = rsp_rdata; r_resp = rsp_resp; r_wr = rsp_write;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  initial begin
    int unsigned   lat, n;
    int unsigned   acc [3];
    logic [7:0]    a1;
    logic [31:0]   d1, rd;
    logic [1:0]    rr;
    logic          rw;

    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 0; timeout_clr = 0;
    bresp = 2'b00; rresp = 2'b00; rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk); check("ready_at_release", 32'(cmd_ready), 32'(0));
    @(negedge clk); check("ready_after_release", 32'(cmd_ready), 32'(1));

    // basic write, always-ready slave
    do_cmd(1, 8'h08, 32'h12345678, 4'hF, 0, lat, a1, d1, rd, rr, rw);
    check("wr_awaddr_c1", 32'(a1), 32'h08);
    check("wr_wdata_c1", d1, 32'h12345678);
    check("wr_latency", lat, 3);
    check("wr_rsp_write", 32'(rw), 32'(1));
    check("wr_rsp_resp", 32'(rr), 32'(0));
    check("wr_rsp_rdata", rd, 32'h0);

    // read: AR accepted one cycle late, R data after 5 wait cycles
    rdata = 32'h00000011; ar_delay = 1; r_delay = 5;
    do_cmd(0, 8'h0C, 32'h0, 4'h0, 0, lat, a1, d1, rd, rr, rw);
    check("rd_araddr_c1", 32'(a1), 32'h0C);
    check("rd_latency", lat, 9);
    check("rd_rdata", rd, 32'h00000011);
    check("rd_resp", 32'(rr), 32'(0));
    check("rd_rsp_write", 32'(rw), 32'(0));
    ar_delay = 0; r_delay = 0;

    // skewed write channels: W first, then AW first
    aw_delay = 3; w_delay = 0;
    do_cmd(1, 8'h20, 32'hCAFEF00D, 4'hF, 0, lat, a1, d1, rd, rr, rw);
    check("skew_w_first_latency", lat, 6);
    aw_delay = 0; w_delay = 3;
    do_cmd(1, 8'h24, 32'h0BADBEEF, 4'h5, 0, lat, a1, d1, rd, rr, rw);
    check("skew_aw_first_latency", lat, 6);
    w_delay = 0;

    // misaligned address, SLVERR, response back-pressure for 10 cycles
    bresp = 2'b10;
    do_cmd(1, 8'h0B, 32'hA5A50F0F, 4'b0011, 10, lat, a1, d1, rd, rr, rw);
    check("misaligned_awaddr", 32'(a1), 32'h08);
    check("bp_rsp_resp", 32'(rr), 32'(2));
    check("bp_rsp_write", 32'(rw), 32'(1));
    bresp = 2'b00;

    // timeout: AW never accepted until released
    aw_delay = 100000;
    rsp_ready = 1;
    start_cmd(1, 8'h30, 32'h11112222, 4'hF);
    repeat (16) @(negedge clk);
    check("to_before_limit", 32'(timeout_err), 32'(0));
    @(negedge clk);
    check("to_at_limit", 32'(timeout_err), 32'(1));
    check("to_awvalid_held", 32'(awvalid), 32'(1));
    @(posedge clk); #1 timeout_clr = 1;
    @(posedge clk); #1 timeout_clr = 0;
    @(negedge clk);
    check("to_clr_during_stall", 32'(timeout_err), 32'(1));
    aw_delay = 0;
    n = 0;
    while (!rsp_valid && n < WAIT_MAX) begin @(negedge clk); n++; end
    check("to_rsp_wait", 32'(rsp_valid), 32'(1));
    check("to_rsp_resp", 32'(rsp_resp), 32'(0));
    @(posedge clk); #1 rsp_ready = 0;
    @(posedge clk); #1 timeout_clr = 1;
    @(posedge clk); #1 timeout_clr = 0;
    @(negedge clk);
    check("to_clr_idle", 32'(timeout_err), 32'(0));

    // reset while waiting for read data
    rdata = 32'h00000055; r_delay = 8;
    rsp_ready = 1;
    start_cmd(0, 8'h14, 32'h0, 4'h0);
    n = 0;
    while (!rready && n < WAIT_MAX) begin @(negedge clk); n++; end
    check("rst_rready_wait", 32'(rready), 32'(1));
    #2 rst_n = 0;
    #1;
    check("rst_rready", 32'(rready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); check("rst_ready_release", 32'(cmd_ready), 32'(0));
    @(negedge clk); check("rst_ready_next", 32'(cmd_ready), 32'(1));
    r_delay = 0;

    // read after reset, DECERR passed through
    rdata = 32'hDEADBEEF; rresp = 2'b11;
    do_cmd(0, 8'h0C, 32'h0, 4'h0, 0, lat, a1, d1, rd, rr, rw);
    check("post_rst_latency", lat, 3);
    check("post_rst_rdata", rd, 32'hDEADBEEF);
    check("post_rst_resp", 32'(rr), 32'(3));
    rresp = 2'b00;

    // back-to-back reads with rsp_ready held high
    rdata = 32'h00000042; rsp_ready = 1;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h10;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!cmd_ready && n < WAIT_MAX);
      check("b2b_accept_wait", 32'(cmd_ready), 32'(1));
      acc[k] = cyc;
    end
    @(posedge clk); #1 cmd_valid = 0;
    check("b2b_period0", acc[1] - acc[0], 4);
    check("b2b_period1", acc[2] - acc[1], 4);
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < WAIT_MAX);
    check("b2b_drain", 32'(busy), 32'(0));
    @(posedge clk); #1 rsp_ready = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that turns single-word register commands from PL logic into AXI4-Lite write/read transactions, and returns one response per command. It is the other end of the team's 64-register AXI-Lite slave register bank. It lets PL-side sequencers and test harnesses program and poll register-mapped blocks over the same bus the PS uses. There is one outstanding transaction at a time, with a sticky timeout monitor.

## Interface
Parameters:
- ADDR_W, 8, AXI address width (byte address).
- TIMEOUT_CYCLES, 1024, bus-stall limit in cycles; 0 disables the monitor; maximum 65535.

Ports:
- m00_axi_aclk  in  1  the single clock.
- m00_axi_aresetn  in  1  asynchronous active-low reset.
- cmd_valid / cmd_ready  in/out  1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid / rsp_ready  out/in  1  response handshake.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  32  read data (0 for writes).
- rsp_resp  out  2  BRESP/RRESP of the transaction.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky stall flag.
- timeout_clr  in  1  clears timeout_err.
- m00_axi_awaddr  out  ADDR_W; m00_axi_awprot  out  3; m00_axi_awvalid  out  1; m00_axi_awready  in  1.
- m00_axi_wdata  out  32; m00_axi_wstrb  out  4; m00_axi_wvalid  out  1; m00_axi_wready  in  1.
- m00_axi_bresp  in  2; m00_axi_bvalid  in  1; m00_axi_bready  out  1.
- m00_axi_araddr  out  ADDR_W; m00_axi_arprot  out  3; m00_axi_arvalid  out  1; m00_axi_arready  in  1.
- m00_axi_rdata  in  32; m00_axi_rresp  in  2; m00_axi_rvalid  in  1; m00_axi_rready  out  1.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid, capture the command into registers.
  - The address is forced word-aligned (bits [1:0]=0).
  - Go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ: awvalid and wvalid are asserted together.
  - Each valid drops independently after its own handshake (awvalid&awready, wvalid&wready); AW may complete before W or after it.
  - When both are done (including same cycle), go to WR_RESP.
- WR_RESP: bready=1. On bvalid, latch bresp, set rsp_write=1 and rsp_rdata=0, go to RSP.
- RD_REQ: arvalid=1. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, latch rdata and rresp, set rsp_write=0, go to RSP.
- RSP: rsp_valid=1; response fields are held stable. On rsp_ready, go to IDLE.
- Valid stability: any asserted AXI valid stays high, with stable payload, until its handshake completes. This holds even after a timeout; the block never abandons a transaction.
- Protection: awprot = arprot = 3'b000 always.
- Stall monitor: a 16-bit counter clears on entry to WR_REQ/RD_REQ.
  - It increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA, and saturates.
  - When it reaches TIMEOUT_CYCLES (nonzero), timeout_err is set.
  - timeout_err stays set until a timeout_clr pulse. If set and clear occur in the same cycle, set wins.
- Reset (asynchronous, any state): FSM to IDLE.
  - All AXI valid/ready outputs, rsp_valid, busy and timeout_err go to 0; the counter and data registers go to 0.
  - cmd_ready=1 from the first clock after reset release.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Command accepted at edge 0 → awvalid/wvalid (or arvalid) high in cycle 1.
- With an always-ready slave:
  - AW/W (or AR) handshake in cycle 1.
  - bready (or rready) high in cycle 2; slave responds in cycle 2.
  - rsp_valid high in cycle 3.
  - Minimum command-to-response latency: 3 cycles.
  - Back-to-back commands: one accepted every 4 cycles when rsp_ready is held high.
- cmd_ready falls the cycle after acceptance and returns the cycle after the rsp handshake.
- bready/rready are asserted only in WR_RESP/RD_DATA. A bvalid/rvalid arriving earlier is simply held by the slave.

## Test plan
- Write: addr 0x08, data 0x12345678, wstrb 0xF, slave ready immediately.
  - Required: awaddr=0x08, wdata=0x12345678 in cycle 1; rsp_valid in cycle 3 with rsp_write=1, rsp_resp=0.
- Read: addr 0x0C, slave returns 0x00000011 after 5 wait cycles on rvalid.
  - Required: rsp_rdata=0x00000011, rsp_resp=0, rsp_write=0; arvalid dropped after arready.
- Skewed write channels: wready 3 cycles before awready, then the reverse order.
  - Required: wvalid/awvalid drop individually; bready asserts only after both handshakes; exactly one response.
- Misaligned address and response back-pressure: cmd_addr 0x0B; rsp_ready held low for 10 cycles.
  - Required: awaddr=0x08; rsp fields stable for 10 cycles; cmd_ready stays 0 until the rsp handshake.
- Timeout: TIMEOUT_CYCLES=16, slave never asserts awready.
  - Required: timeout_err=1 after 16 cycles in WR_REQ, awvalid still 1.
  - timeout_clr while the stall persists: timeout_err stays 1 (counter saturated at or past the limit).
  - After awready/bvalid arrive, the transaction completes normally.
- Reset mid-read: assert m00_axi_aresetn low in RD_DATA.
  - Required: rready, rsp_valid, busy go to 0 immediately; cmd_ready=1 one cycle after release; the next command completes normally.
